// File: rtl/asg_seq_pkg.sv
// Shared types and default constants for the arbitrary signal generator segment sequencer.
package asg_seq_pkg;

  localparam int unsigned ASG_NSEG_DEFAULT   = 4;
  localparam int unsigned ASG_CYC_W_DEFAULT  = 16;
  localparam int unsigned ASG_REP_W_DEFAULT  = 16;
  localparam int unsigned ASG_US_DIV_DEFAULT = 125;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DELAY = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/asg_seq_dly_timer.sv
// Microsecond delay timer: clock prescaler feeding a 32-bit microsecond down-counter.
// A load with a non-zero value arms it; expire pulses on the last enabled clock of the delay.
module asg_seq_dly_timer
  import asg_seq_pkg::*;
#(
  parameter int unsigned US_DIV = ASG_US_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic        enable,
  output logic        expire
);

  localparam int unsigned PRE_W = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(US_DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [31:0]      us_q;
  logic             active_q;

  // Combinational so the owner can leave its wait state on exactly value*US_DIV clocks.
  assign expire = active_q & enable & (pre_q == '0) & (us_q == 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q    <= '0;
      us_q     <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      pre_q    <= PRE_TOP;
      us_q     <= value;
      active_q <= (value != 32'd0);
    end else if (enable && active_q) begin
      if (pre_q == '0) begin
        pre_q <= PRE_TOP;
        us_q  <= us_q - 32'd1;
        if (us_q == 32'd1)
          active_q <= 1'b0;
      end else begin
        pre_q <= pre_q - PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/asg_seq_ctrl.sv
// Segment sequencer for one double-buffered ASG channel: arms on trigger/software start,
// walks segments with per-segment pass counts and repeats with a us pause. Build option: ASG_SEQ_INF_REP_EN.
module asg_seq_ctrl
  import asg_seq_pkg::*;
#(
  parameter int unsigned NSEG   = ASG_NSEG_DEFAULT,
  parameter int unsigned CYC_W  = ASG_CYC_W_DEFAULT,
  parameter int unsigned REP_W  = ASG_REP_W_DEFAULT,
  parameter int unsigned US_DIV = ASG_US_DIV_DEFAULT
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rst_i,
  input  logic                    enable_i,
  input  logic                    trig_i,
  input  logic                    sw_start_i,
  input  logic [$clog2(NSEG)-1:0] seg_last_i,
  input  logic [NSEG*CYC_W-1:0]   seg_cyc_i,
  input  logic [REP_W-1:0]        rep_num_i,
  input  logic [31:0]             rep_dly_i,
  input  logic                    wrap_i,
  output logic [$clog2(NSEG)-1:0] seg_sel_o,
  output logic                    dp_rst_o,
  output logic                    dp_run_o,
  output logic                    trig_out_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [REP_W-1:0]        rep_cnt_o
);

  localparam int unsigned SEG_W = $clog2(NSEG);

  state_e             state;
  logic               trig_q;
  logic [CYC_W-1:0]   pass_q;

  logic [SEG_W-1:0]       seg_last_sh;
  logic [NSEG*CYC_W-1:0]  seg_cyc_sh;
  logic [REP_W-1:0]       rep_num_sh;
  logic [31:0]            rep_dly_sh;

  logic               start_evt;
  logic [CYC_W-1:0]   cyc_cur;
  logic [CYC_W-1:0]   pass_inc;
  logic [SEG_W-1:0]   seg_nxt;
  logic               seg_end;
  logic               more_seg;
  logic               rep_fin;
  logic               tmr_load;
  logic               tmr_en;
  logic               tmr_expire;

  function automatic logic [CYC_W-1:0] cyc_of(input logic [NSEG*CYC_W-1:0] tbl,
                                              input logic [SEG_W-1:0]      k);
    return tbl[k*CYC_W +: CYC_W];
  endfunction

  assign start_evt = enable_i & (state == ARMED) & ((trig_i & ~trig_q) | sw_start_i);
  assign cyc_cur   = cyc_of(seg_cyc_sh, seg_sel_o);
  assign pass_inc  = pass_q + CYC_W'(1);
  assign seg_nxt   = seg_sel_o + SEG_W'(1);
  assign more_seg  = (seg_sel_o < seg_last_sh);

  // Zero-pass segments end in LOAD itself; running segments end on their last wrap.
  assign seg_end = ((state == LOAD) && (cyc_cur == '0)) ||
                   ((state == RUN) && wrap_i && (pass_inc == cyc_cur));

`ifdef ASG_SEQ_INF_REP_EN
  assign rep_fin = (rep_num_sh != '1) && (rep_cnt_o == rep_num_sh);
`else
  assign rep_fin = (rep_cnt_o == rep_num_sh);
`endif

  // Timer is held loaded everywhere except DELAY, so it starts counting on DELAY entry.
  assign tmr_load = (state != DELAY);
  assign tmr_en   = (state == DELAY);

  asg_seq_dly_timer #(
    .US_DIV (US_DIV)
  ) u_dly_timer (
    .clk    (dac_clk_i),
    .rst    (dac_rst_i),
    .load   (tmr_load),
    .value  (rep_dly_sh),
    .enable (tmr_en),
    .expire (tmr_expire)
  );

  // Shadow copies: the bus may rewrite live registers mid-sequence.
  always_ff @(posedge dac_clk_i) begin
    if (start_evt) begin
      seg_last_sh <= seg_last_i;
      seg_cyc_sh  <= seg_cyc_i;
      rep_num_sh  <= rep_num_i;
      rep_dly_sh  <= rep_dly_i;
    end
  end

  always_ff @(posedge dac_clk_i or posedge dac_rst_i) begin
    if (dac_rst_i) begin
      state      <= IDLE;
      trig_q     <= 1'b0;
      pass_q     <= '0;
      seg_sel_o  <= '0;
      dp_rst_o   <= 1'b0;
      dp_run_o   <= 1'b0;
      trig_out_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      rep_cnt_o  <= '0;
    end else begin
      trig_q     <= trig_i;
      dp_rst_o   <= 1'b0;
      trig_out_o <= 1'b0;
      done_o     <= 1'b0;
      if (!enable_i) begin
        state    <= IDLE;
        dp_run_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          IDLE:  state <= ARMED;
          ARMED: begin
            if (start_evt) begin
              state      <= LOAD;
              seg_sel_o  <= '0;
              pass_q     <= '0;
              rep_cnt_o  <= '0;
              trig_out_o <= 1'b1;
              busy_o     <= 1'b1;
              // Shadows are not yet valid here, so peek at the live segment-0 count.
              dp_rst_o   <= (seg_cyc_i[CYC_W-1:0] != '0);
            end
          end
          LOAD: begin
            pass_q <= '0;
            if (cyc_cur != '0) begin
              state    <= RUN;
              dp_run_o <= 1'b1;
            end
          end
          RUN: begin
            if (wrap_i)
              pass_q <= pass_inc;
          end
          DELAY: begin
            if (tmr_expire) begin
              state    <= LOAD;
              dp_rst_o <= (cyc_cur != '0);
            end
          end
          DONE:    state <= ARMED;
          default: state <= IDLE;
        endcase

        if (seg_end) begin
          dp_run_o <= 1'b0;
          if (more_seg) begin
            state     <= LOAD;
            seg_sel_o <= seg_nxt;
            dp_rst_o  <= (cyc_of(seg_cyc_sh, seg_nxt) != '0);
          end else if (rep_fin) begin
            state  <= DONE;
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            rep_cnt_o <= rep_cnt_o + REP_W'(1);
            seg_sel_o <= '0;
            if (rep_dly_sh != 32'd0) begin
              state <= DELAY;
            end else begin
              state    <= LOAD;
              dp_rst_o <= (cyc_of(seg_cyc_sh, '0) != '0);
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_asg_seq_ctrl.sv
// Directed bench for asg_seq_ctrl: reset, segment walk, repetition delay, skip, enable drop, long repeat.
module tb_asg_seq_ctrl;

  localparam int NSEG   = 4;
  localparam int CYC_W  = 16;
  localparam int REP_W  = 16;
  localparam int US_DIV = 125;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable_i;
  logic                    trig_i;
  logic                    sw_start_i;
  logic [$clog2(NSEG)-1:0] seg_last_i;
  logic [NSEG*CYC_W-1:0]   seg_cyc_i;
  logic [REP_W-1:0]        rep_num_i;
  logic [31:0]             rep_dly_i;
  logic                    wrap_i;
  logic [$clog2(NSEG)-1:0] seg_sel_o;
  logic                    dp_rst_o;
  logic                    dp_run_o;
  logic                    trig_out_o;
  logic                    busy_o;
  logic                    done_o;
  logic [REP_W-1:0]        rep_cnt_o;

  int checks = 0;
  int errors = 0;
  int rst_pulses = 0;

  always #4 clk = ~clk;

  asg_seq_ctrl #(
    .NSEG   (NSEG),
    .CYC_W  (CYC_W),
    .REP_W  (REP_W),
    .US_DIV (US_DIV)
  ) dut (
    .dac_clk_i  (clk),
    .dac_rst_i  (rst),
    .enable_i   (enable_i),
    .trig_i     (trig_i),
    .sw_start_i (sw_start_i),
    .seg_last_i (seg_last_i),
    .seg_cyc_i  (seg_cyc_i),
    .rep_num_i  (rep_num_i),
    .rep_dly_i  (rep_dly_i),
    .wrap_i     (wrap_i),
    .seg_sel_o  (seg_sel_o),
    .dp_rst_o   (dp_rst_o),
    .dp_run_o   (dp_run_o),
    .trig_out_o (trig_out_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rep_cnt_o  (rep_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rst_pulses += int'(dp_rst_o);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({seg_sel_o, dp_rst_o, dp_run_o, trig_out_o, busy_o, done_o, rep_cnt_o});
  endfunction

  task automatic set_cfg(input int c0, input int c1, input int c2, input int c3,
                         input int last, input int rn, input int rd);
    seg_cyc_i  = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    seg_last_i = 2'(last);
    rep_num_i  = 16'(rn);
    rep_dly_i  = 32'(rd);
  endtask

  task automatic sw_go();
    sw_start_i = 1'b1;
    tick();
    sw_start_i = 1'b0;
    chk("start_trig_out", 32'(trig_out_o), 32'd1);
    chk("start_busy", 32'(busy_o), 32'd1);
  endtask

  // Entered while observing the LOAD cycle of a non-empty segment; returns on the cycle after its last wrap.
  task automatic seg_run(input int seg, input int cyc);
    chk("load_seg", 32'(seg_sel_o), 32'(seg));
    chk("load_dp_rst", 32'(dp_rst_o), 32'd1);
    chk("load_dp_run", 32'(dp_run_o), 32'd0);
    tick();
    chk("run_dp_run", 32'(dp_run_o), 32'd1);
    for (int p = 1; p <= cyc; p++) begin
      wrap_i = 1'b1;
      tick();
      wrap_i = 1'b0;
      if (p < cyc) begin
        chk("mid_rst_run", 32'({dp_rst_o, dp_run_o}), 32'b01);
        chk("mid_seg", 32'(seg_sel_o), 32'(seg));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int d;
    int run_seen;
    int toggles;

    // Reset with random inputs
    rst        = 1'b1;
    enable_i   = 1'($urandom_range(0, 1));
    trig_i     = 1'($urandom_range(0, 1));
    sw_start_i = 1'($urandom_range(0, 1));
    wrap_i     = 1'($urandom_range(0, 1));
    seg_cyc_i  = {$urandom, $urandom};
    seg_last_i = 2'($urandom_range(0, 3));
    rep_num_i  = 16'($urandom);
    rep_dly_i  = $urandom;
    repeat (3) tick();
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_seg_sel", 32'(seg_sel_o), 32'd0);

    enable_i   = 1'b1;
    trig_i     = 1'b0;
    sw_start_i = 1'b0;
    wrap_i     = 1'b0;
    set_cfg(1, 2, 3, 4, 3, 0, 0);
    tick();
    rst = 1'b0;
    toggles = 0;
    repeat (6) begin
      tick();
      if (all_outs() != 32'd0) toggles++;
    end
    chk("idle_quiet", 32'(toggles), 32'd0);

    // Trigger edge, cyc={1,2,3,4}, single run
    base = rst_pulses;
    trig_i = 1'b1;
    tick();
    chk("trig_out", 32'(trig_out_o), 32'd1);
    chk("trig_busy", 32'(busy_o), 32'd1);
    seg_run(0, 1);
    seg_run(1, 2);
    seg_run(2, 3);
    seg_run(3, 4);
    chk("seq1_done", 32'(done_o), 32'd1);
    chk("seq1_busy", 32'(busy_o), 32'd0);
    chk("seq1_run", 32'(dp_run_o), 32'd0);
    chk("seq1_rep_cnt", 32'(rep_cnt_o), 32'd0);
    chk("seq1_dp_rst_count", 32'(rst_pulses - base), 32'd4);
    tick();
    chk("seq1_done_one_cycle", 32'(done_o), 32'd0);
    trig_i = 1'b0;

    // Software start, one repetition with 2 us pause
    set_cfg(1, 2, 3, 4, 3, 1, 2);
    sw_go();
    seg_run(0, 1);
    seg_run(1, 2);
    seg_run(2, 3);
    seg_run(3, 4);
    chk("rep_cnt_after_first", 32'(rep_cnt_o), 32'd1);
    chk("delay_busy", 32'(busy_o), 32'd1);
    chk("delay_no_done", 32'(done_o), 32'd0);
    chk("delay_seg0", 32'(seg_sel_o), 32'd0);
    d = 0;
    run_seen = 0;
    while (dp_rst_o == 1'b0 && d < 400) begin
      if (dp_run_o) run_seen++;
      d++;
      tick();
    end
    chk("delay_cycles", 32'(d), 32'd250);
    chk("delay_run_low", 32'(run_seen), 32'd0);
    seg_run(0, 1);
    seg_run(1, 2);
    seg_run(2, 3);
    seg_run(3, 4);
    chk("seq2_done", 32'(done_o), 32'd1);
    chk("seq2_rep_cnt", 32'(rep_cnt_o), 32'd1);
    tick();

    // Zero-pass segment 1 is skipped in a single LOAD cycle
    set_cfg(1, 0, 1, 0, 2, 0, 0);
    sw_go();
    seg_run(0, 1);
    chk("skip_seg", 32'(seg_sel_o), 32'd1);
    chk("skip_rst_run", 32'({dp_rst_o, dp_run_o}), 32'b00);
    chk("skip_busy", 32'(busy_o), 32'd1);
    tick();
    seg_run(2, 1);
    chk("skip_done", 32'(done_o), 32'd1);
    tick();

    // Trigger during RUN ignored; enable drop wins over terminal wrap
    set_cfg(2, 2, 0, 0, 1, 0, 0);
    sw_go();
    tick();
    chk("en_run", 32'(dp_run_o), 32'd1);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    chk("trig_in_run_ignored", 32'({trig_out_o, dp_rst_o, dp_run_o}), 32'b001);
    chk("trig_in_run_seg", 32'(seg_sel_o), 32'd0);
    wrap_i = 1'b1;
    tick();
    wrap_i   = 1'b1;
    enable_i = 1'b0;
    tick();
    wrap_i = 1'b0;
    chk("drop_run", 32'(dp_run_o), 32'd0);
    chk("drop_busy", 32'(busy_o), 32'd0);
    chk("drop_no_done", 32'(done_o), 32'd0);
    chk("drop_no_rst", 32'(dp_rst_o), 32'd0);
    chk("drop_seg_held", 32'(seg_sel_o), 32'd0);
    enable_i = 1'b1;
    tick();
    tick();
    chk("drop_quiet", 32'({done_o, busy_o, dp_run_o}), 32'd0);

    // All-ones repetition count: no completion within 5 repetitions in either build
    set_cfg(1, 0, 0, 0, 0, 16'hFFFF, 0);
    sw_go();
    for (int r = 1; r <= 5; r++) begin
      seg_run(0, 1);
      chk("long_rep_cnt", 32'(rep_cnt_o), 32'(r));
      chk("long_no_done", 32'(done_o), 32'd0);
      chk("long_busy", 32'(busy_o), 32'd1);
    end

    // Asynchronous reset mid-sequence clears outputs without a clock edge
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 32'd0);
    tick();
    rst = 1'b0;
    toggles = 0;
    repeat (4) begin
      tick();
      if (all_outs() != 32'd0) toggles++;
    end
    chk("no_resume_after_reset", 32'(toggles), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/asg_seq_ctrl.md
# asg_seq_ctrl

Segment sequencer for the double-buffered arbitrary signal generator channel. It arms on an external trigger edge or a software start, then walks the channel's segment register sets in order. For each segment it runs the table a programmed number of passes. It repeats the whole sequence a programmed number of times, with a microsecond-resolution pause between repetitions. The block sits between the system-bus register bank and one channel's table-read datapath, and drives segment select, pointer reload and run enable.

## Interface
- NSEG, 4: number of segment register sets; power of 2.
- CYC_W, 16: width of per-segment pass count.
- REP_W, 16: width of repetition count.
- US_DIV, 125: clocks per 1 µs delay tick (125 MHz).
- dac_clk_i  in  1  DAC clock.
- dac_rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  channel enable level; 0 forces IDLE.
- trig_i  in  1  synchronized trigger level; rising edge starts a sequence.
- sw_start_i  in  1  one-cycle software start pulse.
- seg_last_i  in  $clog2(NSEG)  index of last active segment.
- seg_cyc_i  in  NSEG*CYC_W  per-segment pass count; segment k at [k*CYC_W +: CYC_W].
- rep_num_i  in  REP_W  extra repetitions after the first run.
- rep_dly_i  in  32  delay between repetitions, in µs.
- wrap_i  in  1  one-cycle pulse from datapath: table pass completed.
- seg_sel_o  out  $clog2(NSEG)  active segment index.
- dp_rst_o  out  1  one-cycle pulse: reload read pointer from segment reset offset.
- dp_run_o  out  1  datapath run enable.
- trig_out_o  out  1  one-cycle pulse at sequence start.
- busy_o  out  1  high in LOAD/RUN/DELAY.
- done_o  out  1  one-cycle pulse at sequence completion.
- rep_cnt_o  out  REP_W  completed repetitions of the current sequence.

## Operation
- All outputs are registered. Reset value of every output is 0. State resets to IDLE.
- Shadow registers: seg_last_i, seg_cyc_i, rep_num_i and rep_dly_i are latched on the start event. They are held for the whole sequence. The bus may rewrite the live registers while a sequence runs.
- IDLE: if enable_i=1, go to ARMED.
- ARMED: a start event is (trig_i & ~trig_q) | sw_start_i. On a start event: latch the shadows, set seg=0, pass=0, rep_cnt=0, pulse trig_out_o, and go to LOAD.
- LOAD (1 cycle):
  - pass=0.
  - If cyc[seg]≠0: pulse dp_rst_o and go to RUN.
  - If cyc[seg]=0: skip the segment. No dp_rst_o; apply the segment-end rule.
- RUN: dp_run_o=1. On wrap_i, pass+1; when pass+1==cyc[seg], apply the segment-end rule. Any other wrap only increments pass.
- Segment-end rule:
  - If seg<seg_last: seg+1, go to LOAD.
  - Else if rep_cnt==rep_num: go to DONE.
  - Else: rep_cnt+1 and seg=0; go to DELAY if rep_dly≠0, else LOAD.
- DELAY: dp_run_o=0. Counts rep_dly×US_DIV clocks, then goes to LOAD.
- DONE (1 cycle): pulse done_o, then go to ARMED.
- enable_i=0 in any state means IDLE on the next edge, with dp_run_o=0. This has priority over a simultaneous wrap_i or start event.
- Start events outside ARMED are ignored; no queuing.
- wrap_i outside RUN is ignored.
- An all-zero cyc sequence terminates through LOAD cycles only and never asserts dp_run_o.
- Pass counter width is CYC_W; the terminal compare prevents overflow. The delay counter is 32-bit µs plus a $clog2(US_DIV)-bit prescaler.

## Timing
- Start event sampled at cycle n:
  - n+1: LOAD, seg_sel_o=0, dp_rst_o=1, trig_out_o=1, busy_o=1.
  - n+2: dp_run_o=1.
- Terminal wrap_i at cycle m:
  - m+1: dp_run_o=0, new seg_sel_o, dp_rst_o=1.
  - m+2: dp_run_o=1.
- DELAY entered at m+1: dp_run_o=0 for rep_dly×US_DIV cycles, then 1 LOAD cycle, then RUN.
- Final terminal wrap at m: done_o=1 and busy_o=0 at m+1. Next start is accepted from m+2.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronous). No resume after reset.

## Configuration
- ASG_SEQ_INF_REP_EN defined: rep_num_i == all-ones means infinite repetition. rep_cnt_o wraps; the sequence ends only on enable_i=0.
- Not defined: all-ones is an ordinary count of 2^REP_W−1 extra repetitions.

## Structure
- Package asg_seq_pkg holds:
  - the state enum (IDLE, ARMED, LOAD, RUN, DELAY, DONE);
  - default NSEG, CYC_W, REP_W, US_DIV constants;
  - the ASG_US_DIV_DEFAULT constant.
- Sub-module asg_seq_dly_timer implements the prescaler plus µs down-counter.
  - Inputs: load, value, enable. Output: expire pulse.
  - Reused by other channel controllers.

## Test plan
- Reset with random inputs: all outputs 0, seg_sel_o=0; after release with enable_i=1, state is ARMED and no output toggles until a start.
- seg_last=3, cyc={1,2,3,4}, rep_num=0, trigger edge: seg_sel_o steps 0→1→2→3 after 1/3/6/10 wraps; dp_rst_o pulses 4 times; done_o 1 cycle after wrap 10.
- Same config, rep_num=1, rep_dly=2: dp_run_o=0 for exactly 250 cycles after wrap 10, then seg 0 again; done_o after wrap 20; rep_cnt_o=1.
- cyc[1]=0: seg_sel_o=1 for exactly one cycle with no dp_rst_o and no dp_run_o, then segment 2 starts.
- enable_i dropped during RUN coinciding with a terminal wrap: next cycle dp_run_o=0, busy_o=0, no done_o. A trigger edge during RUN with enable high is ignored.
- With ASG_SEQ_INF_REP_EN, rep_num=16'hFFFF, cyc={1}, seg_last=0: no done_o over 5 repetitions and rep_cnt_o counts 1..5. Without the macro, the same stimulus never completes within the 5 repetitions either (65535 extra repetitions expected).
